// File: rtl/my_seg7_pkg.sv
// Shared constants and the hex font for the multiplexed 7-segment driver.
// Segment order is {a,b,c,d,e,f,g}, active high.
package my_seg7_pkg;

  localparam logic [6:0] SEG7_OFF = 7'b0000000;

  function automatic logic [6:0] seg7_font(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG7_OFF;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      4'hF: s = 7'b1000111;
      default: s = SEG7_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/my_seg7_font.sv
// Combinational hex nibble to 7-segment decode, shared by all digits via the scan mux.
module my_seg7_font
  import my_seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg7_font(nib);
  end

endmodule

// File: rtl/my_seg7_scan.sv
// N-digit multiplexed 7-segment scanner: per-frame snapshot, ghost blanking, PWM dimming.
// Define MY_SEG7_LZB_EN to blank leading zero digits (digit 0 always shown).
module my_seg7_scan
  import my_seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 128,
  parameter int BRIGHT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   num,
  input  logic [N_DIGITS-1:0]     dp,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [N_DIGITS-1:0]     seg_gnd,
  output logic                    frame_start
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] SEL_DIGIT0 = N_DIGITS'(1);

  logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic [4*N_DIGITS-1:0]   num_snap_q, num_snap_d;
  logic [N_DIGITS-1:0]     dp_snap_q, dp_snap_d;
  logic [6:0]              seg_q, seg_d;
  logic                    seg_dp_q, seg_dp_d;
  logic [N_DIGITS-1:0]     seg_gnd_q, seg_gnd_d;
  logic                    frame_start_q, frame_start_d;

  logic                    capture;
  logic                    slot_wrap;
  logic                    blank;
  logic [SW-1:0]           pwm_off;
  logic [BRIGHT_W-1:0]     pwm;
  logic                    lit;
  logic [3:0]              cur_nib;
  logic [6:0]              font_seg;
  logic                    cur_dp;
  logic                    cur_show;

  logic [3:0]              nib [N_DIGITS];
  logic [N_DIGITS-1:0]     show;

  // Counters and snapshot
  always_comb begin
    capture   = (slot_cnt_q == '0) && (digit_q == '0);
    slot_wrap = (slot_cnt_q == SW'(SCAN_DIV - 1));

    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;

    digit_d = digit_q;
    if (slot_wrap) begin
      if ((N_DIGITS == 1) || (digit_q == DW'(N_DIGITS - 1))) begin
        digit_d = '0;
      end else begin
        digit_d = digit_q + 1'b1;
      end
    end

    // The value captured this cycle is already the one displayed this cycle.
    num_snap_d = capture ? num : num_snap_q;
    dp_snap_d  = capture ? dp  : dp_snap_q;
  end

  // Per-digit nibble split and optional leading-zero mask
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign nib[gi] = num_snap_d[4*gi +: 4];
`ifdef MY_SEG7_LZB_EN
    if (gi == 0) begin : g_lsd
      assign show[gi] = 1'b1;
    end else begin : g_upper
      assign show[gi] = |num_snap_d[4*N_DIGITS-1:4*gi];
    end
`else
    assign show[gi] = 1'b1;
`endif
  end

  always_comb begin
    cur_nib  = nib[digit_q];
    cur_dp   = dp_snap_d[digit_q];
    cur_show = show[digit_q];
  end

  my_seg7_font u_font (
    .nib (cur_nib),
    .seg (font_seg)
  );

  // PWM phase restarts at the end of the blank window of every slot
  always_comb begin
    blank   = (slot_cnt_q < SW'(BLANK_CYCLES));
    pwm_off = slot_cnt_q - SW'(BLANK_CYCLES);
    pwm     = pwm_off[BRIGHT_W-1:0];
    lit     = (brightness == {BRIGHT_W{1'b1}}) || (pwm < brightness);
  end

  always_comb begin
    seg_d         = SEG7_OFF;
    seg_dp_d      = 1'b0;
    seg_gnd_d     = '1;
    frame_start_d = capture;

    if (en && !blank) begin
      // Common stays selected through unlit PWM cycles; only segments gate.
      seg_gnd_d = ~(SEL_DIGIT0 << digit_q);
      if (lit) begin
        seg_d    = cur_show ? font_seg : SEG7_OFF;
        seg_dp_d = cur_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q    <= '0;
      digit_q       <= '0;
      num_snap_q    <= '0;
      dp_snap_q     <= '0;
      seg_q         <= SEG7_OFF;
      seg_dp_q      <= 1'b0;
      seg_gnd_q     <= '1;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_q       <= digit_d;
      num_snap_q    <= num_snap_d;
      dp_snap_q     <= dp_snap_d;
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
      seg_gnd_q     <= seg_gnd_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign seg_dp      = seg_dp_q;
  assign seg_gnd     = seg_gnd_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_my_seg7_scan.sv
// Directed bench for my_seg7_scan with 4 digits, 16-cycle slots, 4 blank cycles, 2-bit brightness.
module tb_my_seg7_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] num = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [1:0]  brightness = 2'd0;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  seg_gnd;
  logic        frame_start;

  always #5 clk = ~clk;

  my_seg7_scan #(
    .N_DIGITS     (4),
    .SCAN_DIV     (16),
    .BLANK_CYCLES (4),
    .BRIGHT_W     (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .num         (num),
    .dp          (dp),
    .brightness  (brightness),
    .seg         (seg),
    .seg_dp      (seg_dp),
    .seg_gnd     (seg_gnd),
    .frame_start (frame_start)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  // Expected scan state: t counts clock edges since reset release.
  int         t;
  logic [6:0] pend_font  [4];
  logic [6:0] frame_font [4];
  logic [3:0] frame_dp;
  logic [3:0] gnd_sel [4];
  logic [3:0] lit_pat [4];

  task automatic set_num(input logic [15:0] v, input logic [6:0] f3, input logic [6:0] f2,
                         input logic [6:0] f1, input logic [6:0] f0);
    num = v;
    pend_font[3] = f3;
    pend_font[2] = f2;
    pend_font[1] = f1;
    pend_font[0] = f0;
  endtask

  task automatic tick();
    int   slot;
    int   dg;
    logic on;
    logic lit;
    @(posedge clk);
    if (t % 64 == 0) begin
      frame_font = pend_font;
      frame_dp   = dp;
    end
    slot = t % 16;
    dg   = (t / 16) % 4;
    on   = en && (slot >= 4);
    lit  = 1'b0;
    if (slot >= 4) lit = lit_pat[brightness][3 - ((slot - 4) % 4)];
    #1;
    check("frame_start", frame_start, (t % 64 == 0));
    check("seg_gnd", seg_gnd, on ? gnd_sel[dg] : 4'hF);
    check("seg", seg, (on && lit) ? frame_font[dg] : 7'b0);
    check("seg_dp", seg_dp, on && lit && frame_dp[dg]);
    t++;
  endtask

  initial begin
    t = 0;
    gnd_sel[0] = 4'b1110; gnd_sel[1] = 4'b1101; gnd_sel[2] = 4'b1011; gnd_sel[3] = 4'b0111;
    lit_pat[0] = 4'b0000; lit_pat[1] = 4'b1000; lit_pat[2] = 4'b1100; lit_pat[3] = 4'b1111;
    frame_dp = 4'h0;
    for (int i = 0; i < 4; i++) frame_font[i] = 7'b0;

    // Reset state
    set_num(16'h1234, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011);
    brightness = 2'd3;
    en = 1'b1;
    #12;
    check("rst_seg", seg, 7'b0);
    check("rst_seg_dp", seg_dp, 1'b0);
    check("rst_seg_gnd", seg_gnd, 4'hF);
    check("rst_frame_start", frame_start, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    $display("reset released, checks=%0d errors=%0d", checks, errors);

    // Full-brightness scan of 1234
    repeat (64) tick();
    $display("scan frame 1234 done, checks=%0d errors=%0d", checks, errors);

    // Input change during digit 2 must not tear the current frame
    repeat (37) tick();
    set_num(16'h5678, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111);
    repeat (27) tick();
    repeat (64) tick();
    $display("snapshot 1234->5678 done, checks=%0d errors=%0d", checks, errors);

    // PWM duty codes
    brightness = 2'd2;
    repeat (64) tick();
    brightness = 2'd0;
    repeat (64) tick();
    brightness = 2'd1;
    repeat (40) tick();
    $display("pwm sweep done, checks=%0d errors=%0d", checks, errors);

    // Decimal point and enable gating mid-slot
    brightness = 2'd3;
    dp = 4'b0100;
    repeat (24) tick();
    repeat (64) tick();
    repeat (6) tick();
    en = 1'b0;
    repeat (10) tick();
    en = 1'b1;
    repeat (64) tick();
    dp = 4'b0000;
    $display("dp/en done, checks=%0d errors=%0d", checks, errors);

    // Leading-zero handling; finish the current frame first
    while (t % 64 != 0) tick();
`ifdef MY_SEG7_LZB_EN
    set_num(16'h0050, 7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110);
`else
    set_num(16'h0050, 7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110);
`endif
    repeat (64) tick();
`ifdef MY_SEG7_LZB_EN
    set_num(16'h0000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110);
`else
    set_num(16'h0000, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);
`endif
    repeat (64) tick();
    $display("leading zero frames done, checks=%0d errors=%0d", checks, errors);

    // Reset asserted mid-slot while a digit is lit, then restart at digit 0
    set_num(16'h1234, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011);
    repeat (64 + 22) tick();
    check("pre_rst_lit_gnd", seg_gnd, 4'b1101);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_seg", seg, 7'b0);
    check("midrst_seg_dp", seg_dp, 1'b0);
    check("midrst_seg_gnd", seg_gnd, 4'hF);
    check("midrst_frame_start", frame_start, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    t = 0;
    repeat (40) tick();
    $display("mid-slot reset restart done, checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
